// File: rtl/uart_pkg.sv
// State encodings and bit-timing helper shared by the uart_duplex slice.
package uart_pkg;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_START     = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_PARITY    = 3'd3;
    localparam logic [2:0] RX_STOP      = 3'd4;
    localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

    // Start-bit resample point, measured from the detected falling edge.
    function automatic int unsigned half_bit(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial input; resets to the idle-high level.
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_duplex.sv
// Full-duplex UART with independent TX and RX engines.
// Define UART_PARITY_EN to add an even-parity bit and the parErr output.
module uart_duplex
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 54,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              tx,
    input  logic [DATA_W-1:0] idata,
    input  logic              newTxData,
    output logic              txBusy,
    output logic [DATA_W-1:0] odata,
    output logic              newRxData,
    output logic              rxBusy,
`ifdef UART_PARITY_EN
    output logic              parErr,
`endif
    output logic              frameErr
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W    = $clog2(DATA_W);
    localparam int unsigned HALF_BIT = half_bit(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_END = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_END = BIT_W'(STOP_BITS - 1);

    // ---------------- transmitter ----------------
    logic [2:0]        tx_state;
    logic [CNT_W-1:0]  tx_cnt;
    logic [BIT_W-1:0]  tx_bit;
    logic [DATA_W-1:0] tx_shift;
`ifdef UART_PARITY_EN
    logic              tx_par;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
            tx       <= 1'b1;
            txBusy   <= 1'b0;
        end else if (tx_state == TX_IDLE) begin
            if (newTxData) begin
                tx_state <= TX_START;
                tx_cnt   <= '0;
                tx_shift <= idata;
`ifdef UART_PARITY_EN
                tx_par   <= ^idata;
`endif
                tx       <= 1'b0;
                txBusy   <= 1'b1;
            end
        end else if (tx_cnt != BIT_END) begin
            tx_cnt <= tx_cnt + 1'b1;
        end else begin
            tx_cnt <= '0;
            case (tx_state)
                TX_START: begin
                    tx_state <= TX_DATA;
                    tx_bit   <= '0;
                    tx       <= tx_shift[0];
                end
                TX_DATA: begin
                    tx_shift <= tx_shift >> 1;
                    if (tx_bit == DATA_END) begin
                        tx_bit <= '0;
`ifdef UART_PARITY_EN
                        tx_state <= TX_PARITY;
                        tx       <= tx_par;
`else
                        tx_state <= TX_STOP;
                        tx       <= 1'b1;
`endif
                    end else begin
                        tx_bit <= tx_bit + 1'b1;
                        tx     <= tx_shift[1];
                    end
                end
`ifdef UART_PARITY_EN
                TX_PARITY: begin
                    tx_state <= TX_STOP;
                    tx       <= 1'b1;
                end
`endif
                TX_STOP: begin
                    if (tx_bit == STOP_END) begin
                        tx_state <= TX_IDLE;
                        tx_bit   <= '0;
                        txBusy   <= 1'b0;
                    end else begin
                        tx_bit <= tx_bit + 1'b1;
                    end
                end
                default: begin
                    tx_state <= TX_IDLE;
                    tx       <= 1'b1;
                    txBusy   <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic              rx_s;
    logic              rx_prev;
    logic [2:0]        rx_settle;
    logic [2:0]        rx_state;
    logic [CNT_W-1:0]  rx_cnt;
    logic [BIT_W-1:0]  rx_bit;
    logic [DATA_W-1:0] rx_shift;
`ifdef UART_PARITY_EN
    logic              rx_par_bad;
`endif

    uart_sync2 u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_prev    <= 1'b1;
            rx_settle  <= '0;
            rxBusy     <= 1'b0;
            odata      <= '0;
            newRxData  <= 1'b0;
            frameErr   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad <= 1'b0;
            parErr     <= 1'b0;
`endif
        end else begin
            rx_prev   <= rx_s;
            // Edge detection waits until the synchronizer's reset value has flushed,
            // so a line held low across reset is not mistaken for a start bit.
            rx_settle <= {rx_settle[1:0], 1'b1};
            newRxData <= 1'b0;
            frameErr  <= 1'b0;
`ifdef UART_PARITY_EN
            parErr    <= 1'b0;
`endif
            case (rx_state)
                RX_IDLE: begin
                    if (rx_settle[2] && rx_prev && !rx_s) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt <= '0;
                        if (rx_s) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_state <= RX_DATA;
                            rx_bit   <= '0;
                            rxBusy   <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[DATA_W-1:1]};
                        if (rx_bit == DATA_END) begin
                            rx_bit <= '0;
`ifdef UART_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt     <= '0;
                        rx_par_bad <= rx_s ^ (^rx_shift);
                        rx_state   <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
`endif
                RX_STOP: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt <= '0;
                        rxBusy <= 1'b0;
                        if (rx_s) begin
                            odata     <= rx_shift;
                            newRxData <= 1'b1;
`ifdef UART_PARITY_EN
                            parErr    <= rx_par_bad;
`endif
                            rx_state  <= RX_IDLE;
                        end else begin
                            frameErr <= 1'b1;
                            rx_state <= RX_WAIT_HIGH;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                    rxBusy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_duplex.sv
// Directed bench for uart_duplex: a frame-level model predicts tx/txBusy per cycle and
// the sequence of received words and framing errors, checked on every falling edge.
module tb_uart_duplex;

    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_drv;
    logic       loop;
    logic       rx_line;
    logic       tx;
    logic [7:0] idata;
    logic       newTxData;
    logic       txBusy;
    logic [7:0] odata;
    logic       newRxData;
    logic       rxBusy;
    logic       frameErr;
`ifdef UART_PARITY_EN
    logic       parErr;
    logic       last_par;
`endif

    assign rx_line = loop ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_duplex #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (8),
        .STOP_BITS    (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx_line),
        .tx        (tx),
        .idata     (idata),
        .newTxData (newTxData),
        .txBusy    (txBusy),
        .odata     (odata),
        .newRxData (newRxData),
        .rxBusy    (rxBusy),
`ifdef UART_PARITY_EN
        .parErr    (parErr),
`endif
        .frameErr  (frameErr)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- model ----------------
    typedef struct {
        bit         ferr;
        logic [7:0] data;
        bit         perr;
    } rx_ev_t;

    rx_ev_t     exp_rx[$];
    bit         txq[$];
    bit         was_busy;
    bit         m_tx;
    bit         m_busy;
    logic [7:0] m_odata = 8'h00;
    int         nrx_cnt = 0;
    int         ferr_cnt = 0;
    int         rxb_cnt = 0;
    logic [7:0] last_rx_data = 8'h00;

    // Each queued entry is the expected tx level for one clock cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            txq.delete();
        end else begin
            was_busy = (txq.size() != 0);
            if (was_busy) void'(txq.pop_front());
            if (!was_busy && newTxData) begin
                repeat (CPB) txq.push_back(1'b0);
                for (int i = 0; i < 8; i++) repeat (CPB) txq.push_back(idata[i]);
                if (PAR_EN) repeat (CPB) txq.push_back(^idata);
                repeat (CPB) txq.push_back(1'b1);
                if (loop) exp_rx.push_back('{ferr: 1'b0, data: idata, perr: 1'b0});
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            exp_rx.delete();
            m_odata = 8'h00;
        end
        m_busy = (txq.size() != 0);
        m_tx   = m_busy ? txq[0] : 1'b1;
        chk("tx", tx, m_tx);
        chk("txBusy", txBusy, m_busy);
        if (rxBusy) rxb_cnt++;
        if (newRxData) begin
            nrx_cnt++;
            last_rx_data = odata;
`ifdef UART_PARITY_EN
            last_par = parErr;
`endif
            chk("rx_word_expected", exp_rx.size() != 0 && !exp_rx[0].ferr, 1);
            if (exp_rx.size() != 0 && !exp_rx[0].ferr) begin
                m_odata = exp_rx[0].data;
`ifdef UART_PARITY_EN
                chk("parErr", parErr, exp_rx[0].perr);
`endif
                void'(exp_rx.pop_front());
            end
        end
`ifdef UART_PARITY_EN
        else chk("parErr_idle", parErr, 0);
`endif
        if (frameErr) begin
            ferr_cnt++;
            chk("frameErr_expected", exp_rx.size() != 0 && exp_rx[0].ferr, 1);
            if (exp_rx.size() != 0 && exp_rx[0].ferr) void'(exp_rx.pop_front());
        end
        chk("odata", odata, m_odata);
    end

    // ---------------- stimulus ----------------
    task automatic send_rx(input logic [7:0] d, input logic stop_v, input logic par_v);
        rx_drv = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            tick(CPB);
        end
        if (PAR_EN) begin
            rx_drv = par_v;
            tick(CPB);
        end
        rx_drv = stop_v;
        tick(CPB);
        rx_drv = 1'b1;
    endtask

    task automatic expect_rx(input bit ferr, input logic [7:0] d, input bit perr);
        exp_rx.push_back('{ferr: ferr, data: d, perr: perr});
    endtask

    bit exp_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int busy_n;
    int idle_n;
    int nrx_base;
    int ferr_base;
    int rxb_base;

    initial begin
        reset     = 1'b1;
        rx_drv    = 1'b1;
        loop      = 1'b0;
        idata     = 8'h00;
        newTxData = 1'b0;
        tick(3);
        chk("rst_tx", tx, 1);
        chk("rst_txBusy", txBusy, 0);
        chk("rst_rxBusy", rxBusy, 0);
        chk("rst_newRxData", newRxData, 0);
        chk("rst_frameErr", frameErr, 0);
        chk("rst_odata", odata, 8'h00);
        reset = 1'b0;
        tick(5);

        // Single frame 0xA5: literal waveform and busy length.
        idata = 8'hA5;
        newTxData = 1'b1;
        tick(1);
        newTxData = 1'b0;
        busy_n = 0;
        for (int c = 0; c < 50; c++) begin
            if (c < 40 && (c % CPB) == 1) chk($sformatf("a5_bit%0d", c / CPB), tx, exp_a5[c / CPB]);
            if (txBusy) busy_n++;
            tick(1);
        end
        chk("a5_busy_cycles", busy_n, PAR_EN ? 44 : 40);

        // Held request: exactly one idle cycle between frames.
        idata = 8'h12;
        newTxData = 1'b1;
        tick(1);
        idle_n = 0;
        for (int c = 0; c < (PAR_EN ? 89 : 81); c++) begin
            if (!txBusy) idle_n++;
            tick(1);
        end
        newTxData = 1'b0;
        chk("b2b_idle_cycles", idle_n, 1);
        tick(50);

        // Request during busy is dropped; looped frame 0x81 arrives.
        loop = 1'b1;
        idata = 8'h81;
        newTxData = 1'b1;
        tick(1);
        newTxData = 1'b0;
        tick(10);
        idata = 8'h7E;
        newTxData = 1'b1;
        tick(2);
        newTxData = 1'b0;
        tick(60);
        chk("drop_odata", odata, 8'h81);

        // Loopback 0x3C.
        nrx_base = nrx_cnt;
        ferr_base = ferr_cnt;
        idata = 8'h3C;
        newTxData = 1'b1;
        tick(1);
        newTxData = 1'b0;
        tick(55);
        chk("loop_pulses", nrx_cnt - nrx_base, 1);
        chk("loop_odata", odata, 8'h3C);
        chk("loop_frameErr", ferr_cnt - ferr_base, 0);
        loop = 1'b0;
        tick(5);

        // One-cycle low glitch.
        nrx_base = nrx_cnt;
        ferr_base = ferr_cnt;
        rxb_base = rxb_cnt;
        rx_drv = 1'b0;
        tick(1);
        rx_drv = 1'b1;
        tick(20);
        chk("glitch_rxBusy", rxb_cnt - rxb_base, 0);
        chk("glitch_newRxData", nrx_cnt - nrx_base, 0);
        chk("glitch_frameErr", ferr_cnt - ferr_base, 0);

        // Framing error on 0x55, then a good 0x0F.
        nrx_base = nrx_cnt;
        ferr_base = ferr_cnt;
        expect_rx(1'b1, 8'h55, 1'b0);
        send_rx(8'h55, 1'b0, 1'b0);
        tick(10);
        chk("ferr_pulses", ferr_cnt - ferr_base, 1);
        chk("ferr_newRxData", nrx_cnt - nrx_base, 0);
        chk("ferr_odata_kept", odata, 8'h3C);
        expect_rx(1'b0, 8'h0F, 1'b0);
        send_rx(8'h0F, 1'b1, 1'b0);
        tick(10);
        chk("after_ferr_odata", odata, 8'h0F);
        chk("after_ferr_pulses", nrx_cnt - nrx_base, 1);

`ifdef UART_PARITY_EN
        // Bad parity still delivers the word.
        expect_rx(1'b0, 8'h07, 1'b1);
        send_rx(8'h07, 1'b1, 1'b0);
        tick(10);
        chk("par_lit_data", last_rx_data, 8'h07);
        chk("par_lit_perr", last_par, 1);
`else
        chk("last_rx_lit", last_rx_data, 8'h0F);
`endif

        // Reset in the middle of a looped frame.
        loop = 1'b1;
        idata = 8'hC3;
        newTxData = 1'b1;
        tick(1);
        newTxData = 1'b0;
        tick(18);
        chk("mid_txBusy", txBusy, 1);
        chk("mid_rxBusy", rxBusy, 1);
        reset = 1'b1;
        #1;
        chk("async_tx", tx, 1);
        chk("async_txBusy", txBusy, 0);
        chk("async_rxBusy", rxBusy, 0);
        chk("async_odata", odata, 8'h00);
        nrx_base = nrx_cnt;
        ferr_base = ferr_cnt;
        tick(3);
        reset = 1'b0;
        tick(60);
        chk("post_rst_newRxData", nrx_cnt - nrx_base, 0);
        chk("post_rst_frameErr", ferr_cnt - ferr_base, 0);
        loop = 1'b0;

        // Line held low across reset release must not start a frame.
        rx_drv = 1'b0;
        tick(8);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        rxb_base = rxb_cnt;
        nrx_base = nrx_cnt;
        ferr_base = ferr_cnt;
        tick(12);
        rx_drv = 1'b1;
        tick(30);
        chk("low_rel_rxBusy", rxb_cnt - rxb_base, 0);
        chk("low_rel_newRxData", nrx_cnt - nrx_base, 0);
        chk("low_rel_frameErr", ferr_cnt - ferr_base, 0);

        chk("rx_events_drained", exp_rx.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_duplex.md
UART_DUPLEX -- requirements
Module: uart_duplex

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 54, giving clock cycles per bit (range 4..65535).
REQ-002 The module SHALL have parameter DATA_W, default 8, giving data bits per frame (range 5..9).
REQ-003 The module SHALL have parameter STOP_BITS, default 1, giving transmitted stop bits (1 or 2).
REQ-004 The module SHALL have port clk, input, 1, the only clock; all logic is rising-edge.
REQ-005 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The module SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-007 The module SHALL have port tx, output, 1, serial line, idle high, registered.
REQ-008 The module SHALL have port idata, input, DATA_W, transmit word.
REQ-009 The module SHALL have port newTxData, input, 1, transmit request, level-sensitive valid.
REQ-010 The module SHALL have port txBusy, output, 1, high from acceptance until the final stop bit ends.
REQ-011 The module SHALL have port odata, output, DATA_W, last received word, held until the next good frame.
REQ-012 The module SHALL have port newRxData, output, 1, one-cycle pulse when odata updates.
REQ-013 The module SHALL have port rxBusy, output, 1, high from start-bit validation to the stop-bit sample.
REQ-014 The module SHALL have port frameErr, output, 1, one-cycle pulse on a stop-bit-low sample.

Function
REQ-015 TX and RX SHALL be fully independent, so both directions run simultaneously.
REQ-016 A TX frame SHALL be accepted on a clock edge where newTxData=1 and txBusy=0; idata is latched there, and txBusy=1 from the next cycle.
REQ-017 The start bit SHALL begin driving tx on the cycle after acceptance.
REQ-018 The TX frame SHALL be: start(0), DATA_W bits LSB first, [parity], then STOP_BITS stop bits of 1, each bit exactly CLKS_PER_BIT cycles.
REQ-019 txBusy SHALL fall on the cycle after the last stop-bit cycle.
REQ-020 With newTxData held high, back-to-back frames SHALL be separated by exactly one idle cycle.
REQ-021 newTxData while txBusy=1 SHALL be ignored, with no queueing.
REQ-022 rx SHALL pass through a 2-flop synchronizer before any use; all RX latencies count from the synchronized signal.
REQ-023 The RX state machine SHALL have states IDLE, START, DATA, [PARITY], STOP, and WAIT_HIGH.
REQ-024 IDLE->START SHALL occur on a synchronized high-to-low transition.
REQ-025 In START, the line SHALL be resampled after CLKS_PER_BIT/2 cycles (integer division); if high, go to IDLE (glitch reject, no outputs); if low, go to DATA.
REQ-026 DATA SHALL sample each bit every CLKS_PER_BIT cycles (bit centre), shifting in LSB first, for DATA_W samples.
REQ-027 At the STOP sample, high SHALL update odata and pulse newRxData on the next cycle, then go to IDLE.
REQ-028 At the STOP sample, low SHALL pulse frameErr, leave odata unchanged, assert no newRxData, and go to WAIT_HIGH.
REQ-029 WAIT_HIGH SHALL go to IDLE only after the synchronized rx is seen high.
REQ-030 A new start edge SHALL be accepted on the cycle IDLE is re-entered.
REQ-031 All bit and cycle counters SHALL be sized by $clog2 of their parameter and SHALL reset to 0 at each bit boundary, with no wrap beyond terminal count.

Reset
REQ-032 Asserting reset SHALL force, asynchronously and at any point including mid-frame: tx=1, txBusy=0, rxBusy=0, newRxData=0, frameErr=0, odata=0, both state machines to idle, counters to 0, and synchronizer flops to 1.
REQ-033 After reset release, a frame truncated by reset SHALL NOT produce newRxData, and reception SHALL resume only at the next falling edge.

Configuration
REQ-034 Macro UART_PARITY_EN defined: one even-parity bit SHALL be sent after the data bits, and the RX PARITY state SHALL check it.
REQ-035 Under UART_PARITY_EN, output parErr (1 bit) SHALL pulse together with newRxData on mismatch, and the data SHALL still be delivered.
REQ-036 Macro UART_PARITY_EN undefined: there SHALL be no parity bit, no PARITY state, and no parErr port.

Structure
REQ-037 Package uart_pkg SHALL hold the RX and TX state enums and the localparam HALF_BIT derivation helper.
REQ-038 Sub-module uart_sync2 (2-flop synchronizer, reset value 1) SHALL be instantiated for rx.

Verification
REQ-039 With CLKS_PER_BIT=4, DATA_W=8: send 0xA5 -> tx=0 for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; txBusy high for exactly 40 cycles.
REQ-040 tx looped to rx, send 0x3C -> newRxData pulses once, odata=0x3C, frameErr=0.
REQ-041 Drive an rx low glitch of 1 cycle (post-sync) -> no rxBusy, newRxData, or frameErr.
REQ-042 Drive a frame for 0x55 with stop bit 0, then hold rx high -> frameErr pulses once, odata keeps its previous value, and the next valid frame 0x0F is received correctly.
REQ-043 Assert reset at data bit 3 of an RX frame and a TX frame -> tx=1 immediately, txBusy=0, and no newRxData afterwards.
REQ-044 With UART_PARITY_EN defined: send 0x07 with the parity bit forced to 0 -> newRxData=1, odata=0x07, parErr=1 in the same cycle.
